ram_config_agu: RTL

- Multi-dimensional successor to the single-word RAM config decoder.
- Accepts a header word plus 1..MAX_DIM dimension words from the configuration token stream and latches them.
- Runs a nested-loop address generator, emitting one element address per cycle to the RAM load/store path under stall back-pressure.
- Sits between the config token input of a RAM tile and its load/store datapath.

---
 rtl/ram_config_agu_pkg.sv | 46 ++++
 rtl/ram_agu_loop_ctr.sv | 36 +++
 rtl/ram_config_agu.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_config_agu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_config_agu_pkg
// Brief    : Shared types and field positions for the multi-dimensional RAM
//            config address generator.
// Revision : 1.0
// ============================================================================
package ram_config_agu_pkg;

    localparam int c_FTK_WIDTH_DATA = 32;

    typedef struct packed {
        logic                        v;
        logic [c_FTK_WIDTH_DATA-1:0] d;
    } FTk_t;

    // Header word fields
    localparam int c_HDR_SHARE     = 31;
    localparam int c_HDR_DECR      = 30;
    localparam int c_HDR_MODE_MSB  = 29;
    localparam int c_HDR_MODE_LSB  = 28;
    localparam int c_HDR_INDIRECT  = 27;
    localparam int c_HDR_NDIM_MSB  = 26;
    localparam int c_HDR_NDIM_LSB  = 24;
    localparam int c_HDR_BASE_LSB  = 0;

    // Dimension word: length at the bottom, stride directly above it
    localparam int c_DIM_LEN_LSB   = 0;

    typedef enum logic [1:0] {
        MODE_M8   = 2'b00,
        MODE_M16  = 2'b01,
        MODE_M32  = 2'b10,
        MODE_MRSV = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DIMS = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/ram_agu_loop_ctr.sv
`default_nettype none
// ============================================================================
// Module   : ram_agu_loop_ctr
// Brief    : One loop dimension: index counter with carry into the next level.
// Revision : 1.0
// ============================================================================
module ram_agu_loop_ctr #(
    parameter int WIDTH_LENGTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_clear,
    input  logic                    i_en,
    input  logic [WIDTH_LENGTH-1:0] i_len,
    output logic [WIDTH_LENGTH-1:0] o_idx,
    output logic                    o_carry
);

    logic [WIDTH_LENGTH-1:0] r_idx;
    logic [WIDTH_LENGTH-1:0] w_idx_last;

    // A zero length behaves as a single-element dimension
    assign w_idx_last = (i_len == '0) ? '0 : i_len - WIDTH_LENGTH'(1);
    assign o_carry    = i_en && (r_idx == w_idx_last);
    assign o_idx      = r_idx;

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_idx <= '0;
        end else if (i_en) begin
            r_idx <= o_carry ? '0 : r_idx + WIDTH_LENGTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_config_agu.sv
`default_nettype none
// ============================================================================
// Module   : ram_config_agu
// Brief    : Latches a header plus dimension words from the config stream and
//            walks a nested loop, emitting one byte address per cycle.
// Revision : 1.0
// ============================================================================
module ram_config_agu
    import ram_config_agu_pkg::*;
#(
    parameter int WIDTH_DATA   = 32,
    parameter int WIDTH_LENGTH = 8,
    parameter int WIDTH_ADDR   = 12,
    parameter int MAX_DIM      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  FTk_t                  I_FTk,
    output logic                  O_Nack,
    input  logic                  I_Abort,
    input  logic                  I_Stall,
    output logic                  O_Valid,
    output logic [WIDTH_ADDR-1:0] O_Addr,
    output logic                  O_Last,
    output logic                  O_Done,
    output logic                  O_Err,
    output logic                  O_Busy,
    output logic                  O_Share,
    output logic                  O_Decrement,
    output logic                  O_Indirect,
    output logic [1:0]            O_Mode
);

    localparam int           c_W        = WIDTH_LENGTH;
    localparam logic [2:0]   c_NDIM_MAX = 3'(MAX_DIM - 1);

    state_e                r_state;
    state_e                w_state_nxt;

    logic                  r_share;
    logic                  r_decr;
    logic                  r_indirect;
    mode_e                 r_mode;
    logic [2:0]            r_ndim;
    logic [2:0]            r_dim_idx;
    logic [WIDTH_ADDR-1:0] r_base;
    logic [c_W-1:0]        r_len    [MAX_DIM];
    logic [c_W-1:0]        r_stride [MAX_DIM];
    logic [WIDTH_ADDR-1:0] r_acc    [MAX_DIM];

    logic [WIDTH_DATA-1:0] w_word;
    logic [2:0]            w_hdr_ndim;
    logic                  w_hdr_acc;
    logic                  w_dim_acc;
    logic                  w_nack;
    logic                  w_advance;
    logic                  w_last;
    logic [MAX_DIM-1:0]    w_en;
    logic [MAX_DIM-1:0]    w_carry;
    logic [MAX_DIM-1:0]    w_at_end;
    logic [c_W-1:0]        w_idx    [MAX_DIM];
    logic [WIDTH_ADDR-1:0] w_offset;
    logic [WIDTH_ADDR-1:0] w_scaled;

    assign w_word     = I_FTk.d[WIDTH_DATA-1:0];
    assign w_hdr_ndim = w_word[c_HDR_NDIM_MSB:c_HDR_NDIM_LSB];
    assign w_advance  = (r_state == ST_RUN) && !I_Stall && !I_Abort;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_nack      = 1'b1;
        w_hdr_acc   = 1'b0;
        w_dim_acc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_nack = 1'b0;
                if (I_FTk.v) begin
                    w_hdr_acc   = 1'b1;
                    w_state_nxt = ST_DIMS;
                end
            end
            ST_DIMS: begin
                w_nack = 1'b0;
                if (I_Abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (I_FTk.v) begin
                    w_dim_acc = 1'b1;
                    if (r_dim_idx == r_ndim) begin
                        w_state_nxt = (r_mode == MODE_MRSV) ? ST_ERR : ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (I_Abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_carry[MAX_DIM-1]) begin
                    // carry out of the outermost level means the final element was taken
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            ST_ERR:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_share    <= 1'b0;
            r_decr     <= 1'b0;
            r_indirect <= 1'b0;
            r_mode     <= MODE_M8;
            r_ndim     <= '0;
            r_dim_idx  <= '0;
            r_base     <= '0;
            for (int k = 0; k < MAX_DIM; k++) begin
                r_len[k]    <= '0;
                r_stride[k] <= '0;
            end
        end else begin
            if (w_hdr_acc) begin
                r_share    <= w_word[c_HDR_SHARE];
                r_decr     <= w_word[c_HDR_DECR];
                r_indirect <= w_word[c_HDR_INDIRECT];
                r_mode     <= mode_e'(w_word[c_HDR_MODE_MSB:c_HDR_MODE_LSB]);
                r_ndim     <= (w_hdr_ndim > c_NDIM_MAX) ? c_NDIM_MAX : w_hdr_ndim;
                r_dim_idx  <= '0;
                r_base     <= w_word[c_HDR_BASE_LSB +: WIDTH_ADDR];
                // unused outer levels must collapse to one iteration
                for (int k = 0; k < MAX_DIM; k++) begin
                    r_len[k]    <= '0;
                    r_stride[k] <= '0;
                end
            end
            if (w_dim_acc) begin
                r_dim_idx <= r_dim_idx + 3'd1;
                for (int k = 0; k < MAX_DIM; k++) begin
                    if (r_dim_idx == 3'(k)) begin
                        r_len[k]    <= w_word[c_DIM_LEN_LSB +: c_W];
                        r_stride[k] <= w_word[c_DIM_LEN_LSB + c_W +: c_W];
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < MAX_DIM; k++) begin : g_dim
        if (k == 0) begin : g_en_first
            assign w_en[k] = w_advance;
        end else begin : g_en_chain
            assign w_en[k] = w_carry[k-1];
        end

        ram_agu_loop_ctr #(
            .WIDTH_LENGTH (c_W)
        ) u_ctr (
            .clock   (clock),
            .reset   (reset),
            .i_clear (w_hdr_acc),
            .i_en    (w_en[k]),
            .i_len   (r_len[k]),
            .o_idx   (w_idx[k]),
            .o_carry (w_carry[k])
        );

        assign w_at_end[k] = (w_idx[k] == ((r_len[k] == '0) ? '0 : r_len[k] - c_W'(1)));

        // running idx*stride for this level, so no multipliers are needed
        always_ff @(posedge clock) begin
            if (reset || w_hdr_acc) begin
                r_acc[k] <= '0;
            end else if (w_en[k]) begin
                r_acc[k] <= w_carry[k] ? '0 : r_acc[k] + WIDTH_ADDR'(r_stride[k]);
            end
        end
    end

    always_comb begin
        w_offset = '0;
        for (int k = 0; k < MAX_DIM; k++) begin
            w_offset = w_offset + r_acc[k];
        end
    end

    assign w_scaled    = w_offset << r_mode;
    assign w_last      = &w_at_end;

    assign O_Nack      = w_nack;
    assign O_Valid     = (r_state == ST_RUN);
    assign O_Addr      = r_decr ? (r_base - w_scaled) : (r_base + w_scaled);
    assign O_Last      = O_Valid && w_last;
    assign O_Done      = (r_state == ST_DONE);
    assign O_Err       = (r_state == ST_ERR);
    assign O_Busy      = (r_state != ST_IDLE);
    assign O_Share     = r_share;
    assign O_Decrement = r_decr;
    assign O_Indirect  = r_indirect;
    assign O_Mode      = r_mode;

endmodule
`default_nettype wire
